// File: rtl/clock_step_generator.sv
// Clock source stage: free-running divided clock plus a debounced,
// fixed-width single-step pulse for the CPU clock selector.
module clock_step_generator #(
  parameter int DIV_WIDTH       = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int PULSE_CYCLES    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] div_sel,
  input  logic                 run_en,
  input  logic                 step_btn,
  output logic                 clk_generator,
  output logic                 adv_clk,
  output logic                 step_busy
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PCNT_W = $clog2(PULSE_CYCLES + 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_CYCLES - 1);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PULSE        = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  logic [DIV_WIDTH-1:0] div_cnt_reg;
  logic [DIV_WIDTH-1:0] eff_m1;
  logic                 clk_gen_reg;

  logic                 sync_1_reg;
  logic                 sync_2_reg;

  logic [1:0]           state_reg, state_next;
  logic [DCNT_W-1:0]    dcnt_reg, dcnt_next;
  logic [PCNT_W-1:0]    pcnt_reg, pcnt_next;
  logic                 adv_reg, adv_next;
  logic                 busy_reg;

  // A zero half-period behaves like one so the divider never stalls.
  always_comb begin
    eff_m1 = (div_sel == '0) ? '0 : div_sel - 1'b1;
  end

  // The >= compare makes a reduced div_sel take effect on the very next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_reg <= '0;
      clk_gen_reg <= 1'b0;
    end else if (!run_en) begin
      div_cnt_reg <= '0;
      clk_gen_reg <= 1'b0;
    end else if (div_cnt_reg >= eff_m1) begin
      div_cnt_reg <= '0;
      clk_gen_reg <= ~clk_gen_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1_reg <= 1'b0;
      sync_2_reg <= 1'b0;
    end else begin
      sync_1_reg <= step_btn;
      sync_2_reg <= sync_1_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    dcnt_next  = dcnt_reg;
    pcnt_next  = pcnt_reg;
    adv_next   = adv_reg;
    case (state_reg)
      IDLE: begin
        if (sync_2_reg) begin
          state_next = PRESS_WAIT;
          dcnt_next  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_2_reg) begin
          state_next = IDLE;
        end else if (dcnt_reg == DCNT_LAST) begin
          state_next = PULSE;
          adv_next   = 1'b1;
          pcnt_next  = '0;
        end else begin
          dcnt_next = dcnt_reg + 1'b1;
        end
      end
      PULSE: begin
        if (pcnt_reg == PCNT_LAST) begin
          state_next = RELEASE_WAIT;
          adv_next   = 1'b0;
          dcnt_next  = '0;
        end else begin
          pcnt_next = pcnt_reg + 1'b1;
        end
      end
      RELEASE_WAIT: begin
        // Any release bounce restarts the stability count.
        if (sync_2_reg) begin
          dcnt_next = '0;
        end else if (dcnt_reg == DCNT_LAST) begin
          state_next = IDLE;
        end else begin
          dcnt_next = dcnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        adv_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      dcnt_reg  <= '0;
      pcnt_reg  <= '0;
      adv_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      dcnt_reg  <= dcnt_next;
      pcnt_reg  <= pcnt_next;
      adv_reg   <= adv_next;
      busy_reg  <= (state_next != IDLE);
    end
  end

  assign clk_generator = clk_gen_reg;
  assign adv_clk       = adv_reg;
  assign step_busy     = busy_reg;

endmodule

// File: tb/tb_clock_step_generator.sv
// Self-checking bench for clock_step_generator with DEBOUNCE_CYCLES=8 and
// PULSE_CYCLES=4; expectations are queued per edge and compared after it.
module tb_clock_step_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] div_sel;
  logic        run_en;
  logic        step_btn;
  logic        clk_generator;
  logic        adv_clk;
  logic        step_busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] exp;
    logic [2:0] mask;
  } sb_t;

  typedef struct {
    logic [15:0] div_sel;
    int          edges;
    logic        exp_clk;
  } div_vec_t;

  sb_t   sb_q[$];
  string name_q[$];

  clock_step_generator #(
    .DIV_WIDTH      (16),
    .DEBOUNCE_CYCLES(8),
    .PULSE_CYCLES   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .div_sel      (div_sel),
    .run_en       (run_en),
    .step_btn     (step_btn),
    .clk_generator(clk_generator),
    .adv_clk      (adv_clk),
    .step_busy    (step_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic compare(input logic [2:0] exp, input logic [2:0] mask, input string name);
    logic [2:0] act;
    act = {clk_generator, adv_clk, step_busy};
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s: {clk_generator,adv_clk,step_busy} got %b required %b (mask %b) at %0t",
               name, act, exp, mask, $time);
    end
  endtask

  // Push the expectation for the coming edge, advance one edge, then pop and compare.
  task automatic step(input logic [2:0] exp, input logic [2:0] mask, input string name);
    sb_t e;
    e.exp  = exp;
    e.mask = mask;
    sb_q.push_back(e);
    name_q.push_back(name);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    compare(e.exp, e.mask, name_q.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp3(input logic c, input logic a, input logic b);
    return {c, a, b};
  endfunction

  div_vec_t vecs[14];
  int       pat4[8];
  int       pat5[5];

  initial begin
    vecs[0]  = '{16'd3, 2, 1'b0};
    vecs[1]  = '{16'd3, 3, 1'b1};
    vecs[2]  = '{16'd3, 5, 1'b1};
    vecs[3]  = '{16'd3, 6, 1'b0};
    vecs[4]  = '{16'd3, 9, 1'b1};
    vecs[5]  = '{16'd0, 1, 1'b1};
    vecs[6]  = '{16'd0, 2, 1'b0};
    vecs[7]  = '{16'd0, 3, 1'b1};
    vecs[8]  = '{16'd1, 2, 1'b0};
    vecs[9]  = '{16'd4, 3, 1'b0};
    vecs[10] = '{16'd4, 4, 1'b1};
    vecs[11] = '{16'd4, 8, 1'b0};
    vecs[12] = '{16'd7, 13, 1'b1};
    vecs[13] = '{16'd7, 14, 1'b0};
    pat4 = '{1, 1, 0, 0, 1, 1, 0, 0};
    pat5 = '{0, 1, 0, 1, 0};

    rst      = 1'b1;
    run_en   = 1'b1;
    div_sel  = 16'd3;
    step_btn = 1'b0;
    #2;
    compare(3'b000, 3'b111, "reset_state");
    tick();
    compare(3'b000, 3'b111, "reset_hold");
    rst = 1'b0;

    // Divide by 3: first rise at edge 3, period 6, 50% duty.
    for (int n = 1; n <= 18; n++)
      step(exp3(((n / 3) % 2) == 1, 1'b0, 1'b0), 3'b111, "t1_div3");
    $display("scenario t1 div_sel=3 done");

    div_sel = 16'd0;
    for (int m = 0; m <= 6; m++)
      step(exp3((m % 2) == 0, 1'b0, 1'b0), 3'b111, "t2_div0_toggle");
    run_en = 1'b0;
    for (int m = 0; m < 5; m++)
      step(3'b000, 3'b111, "t2_run_off");
    $display("scenario t2 div_sel=0 and run_en=0 done");

    div_sel = 16'd6;
    run_en  = 1'b1;
    for (int m = 0; m < 4; m++)
      step(3'b000, 3'b111, "t2_div6_count");
    div_sel = 16'd2;
    step(3'b100, 3'b111, "t2_lower_toggle");
    step(3'b100, 3'b111, "t2_lower_hold");
    step(3'b000, 3'b111, "t2_lower_next");
    $display("scenario lower div_sel below count done");

    for (int v = 0; v < 14; v++) begin
      run_en = 1'b0;
      step(3'b000, 3'b100, "div_restart");
      div_sel = vecs[v].div_sel;
      run_en  = 1'b1;
      for (int n = 1; n < vecs[v].edges; n++) tick();
      step({vecs[v].exp_clk, 2'b00}, 3'b100, "div_vec");
      $display("vec %0d div_sel=%0d edges=%0d clk_generator=%b", v, vecs[v].div_sel,
               vecs[v].edges, clk_generator);
    end

    run_en = 1'b0;
    for (int m = 0; m < 3; m++)
      step(3'b000, 3'b111, "idle");

    // Clean press held 40 edges, then clean release.
    step_btn = 1'b1;
    for (int i = 0; i < 40; i++)
      step(exp3(1'b0, (i >= 10 && i <= 13), (i >= 2)), 3'b111, "t3_press");
    step_btn = 1'b0;
    for (int j = 0; j < 12; j++)
      step(exp3(1'b0, 1'b0, (j < 9)), 3'b111, "t3_release");
    $display("scenario t3 clean press done");

    for (int m = 0; m < 2; m++)
      step(3'b000, 3'b111, "idle");
    for (int i = 0; i < 28; i++) begin
      step_btn = (i < 8) ? (pat4[i] == 1) : 1'b1;
      step(exp3(1'b0, (i >= 18 && i <= 21),
                (i == 2 || i == 3 || i == 6 || i == 7 || i >= 10)), 3'b111, "t4_bounce_press");
    end
    $display("scenario t4 bouncy press done");

    for (int j = 0; j < 18; j++) begin
      step_btn = (j < 5) ? (pat5[j] == 1) : 1'b0;
      step(exp3(1'b0, 1'b0, (j < 13)), 3'b111, "t5_bounce_release");
    end
    $display("scenario t5 bouncy release done");

    for (int m = 0; m < 2; m++)
      step(3'b000, 3'b111, "idle");
    div_sel  = 16'd1;
    run_en   = 1'b1;
    step_btn = 1'b1;
    for (int i = 0; i <= 10; i++)
      step(exp3(((i + 1) % 2) == 1, (i >= 10), (i >= 2)), 3'b111, "t6_before_reset");
    rst = 1'b1;
    #1;
    compare(3'b000, 3'b111, "t6_async_reset");
    tick();
    compare(3'b000, 3'b111, "t6_reset_hold");
    rst = 1'b0;
    for (int i = 0; i < 20; i++)
      step(exp3(((i + 1) % 2) == 1, (i >= 10 && i <= 13), (i >= 2)), 3'b111, "t6_repress");
    step_btn = 1'b0;
    for (int j = 0; j < 12; j++)
      step(exp3(((21 + j) % 2) == 1, 1'b0, (j < 9)), 3'b111, "t6_release");
    $display("scenario t6 reset during pulse done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
